// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter)
// and the clocks-per-bit calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

  function automatic int clk_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so no false start bit is seen after reset.
module uart_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing with mid-bit sampling of the
// synchronized line, one-cycle dv / frame_err pulses.
//
// state   | meaning
// IDLE    | line idle, waiting for a low level
// START   | half bit, confirm start bit still low
// DATA    | sample DATA_WIDTH data bits, LSB first
// STOP    | sample stop bit, report dv or frame_err
// CLEANUP | wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  dv,
  output logic                  frame_err,
  output logic                  active
);

  localparam int CPB   = clk_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  if (CPB < 4) begin : g_rate_check
    $error("uart_rx: CLOCK_RATE/BAUD_RATE must be at least 4");
  end

  logic                  w_rx_s;
  uart_state_e           r_state;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dv;
  logic                  r_frame_err;
  logic                  r_active;

  uart_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (!w_rx_s) begin
            r_state  <= START;
            r_active <= 1'b1;
          end
        end
        START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= DATA;
            end else begin
              r_state  <= IDLE;
              r_active <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt <= '0;
            // Right shift: after DATA_WIDTH bits the first bit lands in the LSB
            r_shift   <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= CLEANUP;
            if (w_rx_s) begin
              r_data <= r_shift;
              r_dv   <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        CLEANUP: begin
          if (w_rx_s) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_active  <= 1'b0;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign dv        = r_dv;
  assign frame_err = r_frame_err;
  assign active    = r_active;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_RATE, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in baud.
REQ-003 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk only.
REQ-006 Port rx  input  1  serial line; asynchronous to clk; idle high.
REQ-007 Port data  output  DATA_WIDTH  last correctly received word, LSB = first data bit on the line.
REQ-008 Port dv  output  1  one-cycle pulse; data is newly valid.
REQ-009 Port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 Port active  output  1  high while a frame is being received.

Function
REQ-011 Frame format SHALL be 8N1-style: one start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1), no parity.
REQ-012 CLK_PER_BIT SHALL equal CLOCK_RATE/BAUD_RATE (integer division); CLK_PER_BIT < 4 SHALL be a elaboration-time error.
REQ-013 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s (2-cycle latency).
REQ-014 clk_cnt width SHALL be $clog2(CLK_PER_BIT); bit_cnt width SHALL be $clog2(DATA_WIDTH)+1; neither SHALL wrap within a frame.
REQ-015 States: IDLE, START, DATA, STOP, CLEANUP.
REQ-016 IDLE: clk_cnt=0, bit_cnt=0; rx_s==0 -> START, else stay.
REQ-017 START: count to CLK_PER_BIT/2-1, then sample rx_s: 0 -> DATA with clk_cnt=0; 1 -> IDLE (glitch rejected, no dv, no frame_err).
REQ-018 DATA: count to CLK_PER_BIT-1, then shift rx_s into bit position bit_cnt, clk_cnt=0, bit_cnt+1; after bit DATA_WIDTH-1 -> STOP.
REQ-019 STOP: count to CLK_PER_BIT-1, then sample rx_s: 1 -> load data from shift register, pulse dv; 0 -> pulse frame_err, data unchanged; both -> CLEANUP.
REQ-020 CLEANUP: stay until rx_s==1 (line break held low SHALL NOT produce further frames), then -> IDLE.
REQ-021 dv and frame_err SHALL each be high for exactly one clk cycle per frame and SHALL never be high together.
REQ-022 active SHALL be high from the cycle after IDLE->START through the last CLEANUP cycle; low in IDLE.
REQ-023 data SHALL hold its value between dv pulses.
REQ-024 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss.
REQ-025 Unreachable state encodings SHALL return to IDLE next cycle.

Reset
REQ-026 rst_n low at a clock edge SHALL set state=IDLE, data=0, dv=0, frame_err=0, active=0, counters=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no dv or frame_err; reception restarts on the next falling edge after release.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding (3-bit, IDLE=0..CLEANUP=4, common with the transmitter) and the CLK_PER_BIT computation.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module uart_sync (parameter-free, 1 bit, reset value 1).

Verification (CLOCK_RATE=1_000_000, BAUD_RATE=100_000 -> CLK_PER_BIT=10 unless noted)
REQ-030 Send 0xA5 with correct framing -> single dv pulse, data=0xA5, frame_err=0, active low again within 2 bit times of stop bit end.
REQ-031 Send 0x3C with stop bit 0, then line high -> frame_err one pulse, no dv, data keeps previous value 0xA5.
REQ-032 rx low pulse of 3 clk cycles on idle line -> no dv, no frame_err, FSM back in IDLE, active pulse only.
REQ-033 Frames 0x00, 0xFF, 0x81 back-to-back -> three dv pulses, data sequence 0x00, 0xFF, 0x81.
REQ-034 rst_n low for 1 cycle during bit 4 of 0x55 -> no dv/frame_err, all outputs 0; next frame 0x12 -> data=0x12.
REQ-035 rx held low for 30 bit times -> exactly one frame_err, no further events until rx returns high; loopback against uart_tx with 0x00..0xFF -> all 256 received intact.
